// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: slave receive states, default field widths
// and the bit order used on the serial lines.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_RX,
        LEN_RX,
        DATA_RX,
        RD_ISSUE
    } state_t;

    localparam int DEF_ADDR_SIZE     = 12;
    localparam int DEF_WORD_SIZE     = 8;
    localparam int DEF_BURST_SIZE    = 15;
    localparam int DEF_SPLIT_TIMEOUT = 16;

    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_shift_rx.sv
// Serial-to-parallel shifter. o_value and o_full already include the bit being shifted
// this cycle, so the caller can latch a completed field on the edge that completes it.
module serial_shift_rx
    import serial_bus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_shift,
    input  logic             i_clr,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_value,
    output logic             o_full
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_val;
    logic [CW-1:0]    r_cnt;
    logic             w_take;
    logic [WIDTH-1:0] w_next;

    assign w_take  = i_shift && (r_cnt != CW'(WIDTH));
    assign w_next  = LSB_FIRST ? ((r_val >> 1) | (WIDTH'(i_bit) << (WIDTH - 1)))
                               : ((r_val << 1) | WIDTH'(i_bit));
    assign o_value = w_take ? w_next : r_val;
    assign o_full  = (r_cnt == CW'(WIDTH)) || (w_take && (r_cnt == CW'(WIDTH - 1)));

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_val <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_val <= w_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// Slave receive port: deserialises address, burst length and write data and issues
// core strobes. Define SLAVE_SPLIT_EN to enable the core-stall split request.
module slave_in_port
    import serial_bus_pkg::*;
#(
    parameter int SLAVE_ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter int BURST_SIZE      = DEF_BURST_SIZE,
    parameter int SPLIT_TIMEOUT   = DEF_SPLIT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slave_select,
    input  logic                       read_en,
    input  logic                       addr_bus,
    input  logic                       burst_size_bus,
    input  logic                       w_data_bus,
    input  logic                       m_valid,
    input  logic                       core_ready,
    output logic                       s_ready,
    output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic [BURST_SIZE-1:0]      burst_len,
    output logic                       rx_done,
    output logic                       rx_err,
    output logic                       split_req
);

    state_t                     r_state;
    logic                       r_read;
    logic                       r_wr_pending;
    logic [SLAVE_ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0]       r_hold;
    logic [BURST_SIZE-1:0]      r_burst_len;
    logic [BURST_SIZE-1:0]      r_word_cnt;

    logic                       w_s_ready, w_sample;
    logic                       w_addr_shift, w_len_shift, w_data_shift;
    logic                       w_addr_full, w_len_full, w_data_full;
    logic [SLAVE_ADDR_SIZE-1:0] w_addr_val;
    logic [BURST_SIZE-1:0]      w_len_val;
    logic [WORD_SIZE-1:0]       w_data_val;
    logic                       w_we, w_re, w_last, w_done;
    logic                       w_rx_state, w_abort, w_split;
    logic                       w_len_done, w_word_done, w_hdr_clr, w_data_clr;

    assign w_s_ready    = core_ready && !r_wr_pending && !rst;
    assign w_sample     = slave_select && w_s_ready;
    assign w_addr_shift = w_sample && ((r_state == IDLE) || (r_state == ADDR_RX));
    assign w_len_shift  = w_sample && (r_state == LEN_RX);
    assign w_data_shift = w_sample && (r_state == DATA_RX) && m_valid;
    assign w_len_done   = w_len_shift && w_len_full;
    assign w_word_done  = w_data_shift && w_data_full;

    assign w_we     = r_wr_pending && core_ready && !rst;
    assign w_re     = (r_state == RD_ISSUE) && core_ready && !rst;
    assign w_last   = (r_word_cnt == r_burst_len - 1'b1);
    assign w_done   = ((w_we && (r_state == DATA_RX)) || w_re) && w_last;

    // A completing strobe outranks a dropped select; RD_ISSUE is already committed.
    assign w_rx_state = (r_state == ADDR_RX) || (r_state == LEN_RX) || (r_state == DATA_RX);
    assign w_abort    = w_rx_state && !slave_select && !w_done && !w_split && !rst;

    assign w_hdr_clr  = rst || w_abort || w_split || w_len_done;
    assign w_data_clr = rst || w_abort || w_split || w_word_done;

`ifdef SLAVE_SPLIT_EN
    localparam int STALL_W = $clog2(SPLIT_TIMEOUT + 1);
    logic [STALL_W-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE) || core_ready) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign w_split = (r_state != IDLE) && !core_ready && !rst &&
                     (r_stall == STALL_W'(SPLIT_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (SPLIT_TIMEOUT > 0);
    assign w_split          = 1'b0;
`endif

    serial_shift_rx #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_rx (
        .clk     (clk),
        .i_shift (w_addr_shift),
        .i_clr   (w_hdr_clr),
        .i_bit   (addr_bus),
        .o_value (w_addr_val),
        .o_full  (w_addr_full)
    );

    serial_shift_rx #(.WIDTH(BURST_SIZE)) u_len_rx (
        .clk     (clk),
        .i_shift (w_len_shift),
        .i_clr   (w_hdr_clr),
        .i_bit   (burst_size_bus),
        .o_value (w_len_val),
        .o_full  (w_len_full)
    );

    serial_shift_rx #(.WIDTH(WORD_SIZE)) u_data_rx (
        .clk     (clk),
        .i_shift (w_data_shift),
        .i_clr   (w_data_clr),
        .i_bit   (w_data_bus),
        .o_value (w_data_val),
        .o_full  (w_data_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_read       <= 1'b0;
            r_wr_pending <= 1'b0;
            r_mem_addr   <= '0;
            r_hold       <= '0;
            r_burst_len  <= '0;
            r_word_cnt   <= '0;
        end else begin
            if (w_we || w_re) begin
                r_mem_addr <= r_mem_addr + 1'b1;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_we) begin
                r_wr_pending <= 1'b0;
            end
            if (w_word_done) begin
                r_wr_pending <= 1'b1;
                r_hold       <= w_data_val;
            end
            case (r_state)
                IDLE: begin
                    if (w_addr_shift) begin
                        r_read  <= read_en;
                        r_state <= w_addr_full ? LEN_RX : ADDR_RX;
                    end
                end
                ADDR_RX: begin
                    if (w_addr_shift && w_addr_full) begin
                        r_state <= LEN_RX;
                    end
                end
                LEN_RX: begin
                    if (w_len_done) begin
                        r_burst_len <= (w_len_val == '0) ? BURST_SIZE'(1) : w_len_val;
                        r_mem_addr  <= w_addr_val;
                        r_word_cnt  <= '0;
                        r_state     <= r_read ? RD_ISSUE : DATA_RX;
                    end
                end
                DATA_RX, RD_ISSUE: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_abort) begin
                r_state <= IDLE;
            end
            if (w_split) begin
                r_state      <= IDLE;
                r_wr_pending <= 1'b0;
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_hold;
    assign mem_we    = w_we;
    assign mem_re    = w_re;
    assign burst_len = r_burst_len;
    assign rx_done   = w_done;
    assign rx_err    = w_abort;
    assign split_req = w_split;

endmodule
